// File: rtl/lake_pkg.sv
// lake_pkg: shared fetch-stage types, constants and address check
package lake_pkg;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} fetch_state_t;
  function automatic logic bad_addr(input logic [31:0] a, input logic [31:0] max_pc);
    return (a[1:0] != 2'b00) || (a > max_pc);
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load/flush/hold controls
module if_id_reg
  import lake_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [INST_W-1:0] inst,
  input  logic [31:0]       pc,
  output logic              valid,
  output logic [INST_W-1:0] id_inst,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_pc4
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid   <= 1'b0;
      id_inst <= NOP_INST;
      id_pc   <= 32'h0;
      id_pc4  <= 32'h4;
    end else if (flush) begin
      valid   <= 1'b0;
      id_inst <= NOP_INST;
    end else if (load) begin
      valid   <= 1'b1;
      id_inst <= inst;
      id_pc   <= pc;
      id_pc4  <= pc + 32'h4;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC + RUN/HALT FSM feeding an IF/ID register, with redirect and bad-address halt
module fetch_stage
  import lake_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_SIZE = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic [31:0]       o_pc,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_id_valid,
  input  logic              i_id_ready,
  output logic [INST_W-1:0] o_id_inst,
  output logic [31:0]       o_id_pc,
  output logic [31:0]       o_id_pc4,
  output logic              o_fault,
  output logic [31:0]       o_fault_pc
);
  localparam logic [31:0] MAX_PC = 32'(IMEM_SIZE - 4);
  fetch_state_t state;
  logic adv, run, pc_bad, redir_bad, load, flush;
  assign adv       = !o_id_valid || i_id_ready;
  assign run       = state == RUN;
  assign pc_bad    = bad_addr(o_pc, MAX_PC);
  assign redir_bad = bad_addr(i_redirect_pc, MAX_PC);
  // a redirect flushes even an entry decode is taking this cycle
  assign flush     = i_redirect || (run && adv && pc_bad);
  assign load      = run && !i_redirect && adv && !pc_bad;
  assign o_fault   = state == HALT;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= RUN;
      o_pc       <= RESET_PC;
      o_fault_pc <= 32'h0;
    end else if (i_redirect) begin
      state      <= redir_bad ? HALT : RUN;
      o_pc       <= redir_bad ? o_pc : i_redirect_pc;
      o_fault_pc <= redir_bad ? i_redirect_pc : o_fault_pc;
    end else if (run && adv) begin
      state      <= pc_bad ? HALT : RUN;
      o_pc       <= pc_bad ? o_pc : o_pc + 32'h4;
      o_fault_pc <= pc_bad ? o_pc : o_fault_pc;
    end
  end
  if_id_reg u_if_id (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (load),
    .flush   (flush),
    .inst    (i_inst),
    .pc      (o_pc),
    .valid   (o_id_valid),
    .id_inst (o_id_inst),
    .id_pc   (o_id_pc),
    .id_pc4  (o_id_pc4)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch, stall, redirect, fault and reset behaviour
module tb_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, redirect, ready;
  logic [31:0] redirect_pc, pc, inst, id_inst, id_pc, id_pc4, fault_pc;
  logic        id_valid, fault;
  logic        rst_b;
  logic [31:0] pc_b, inst_b, id_inst_b, id_pc_b, id_pc4_b, fault_pc_b;
  logic        id_valid_b, fault_b;
  int errors = 0, checks = 0;

  assign inst   = 32'h1000 + (pc >> 2);
  assign inst_b = 32'h1000 + (pc_b >> 2);

  fetch_stage #(.RESET_PC(32'h0), .IMEM_SIZE(256)) dut (
    .i_clk(clk), .i_rst(rst), .o_pc(pc), .i_inst(inst),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .o_id_valid(id_valid), .i_id_ready(ready), .o_id_inst(id_inst),
    .o_id_pc(id_pc), .o_id_pc4(id_pc4), .o_fault(fault), .o_fault_pc(fault_pc)
  );

  fetch_stage #(.RESET_PC(32'h0), .IMEM_SIZE(16)) dut_b (
    .i_clk(clk), .i_rst(rst_b), .o_pc(pc_b), .i_inst(inst_b),
    .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_id_valid(id_valid_b), .i_id_ready(1'b1), .o_id_inst(id_inst_b),
    .o_id_pc(id_pc_b), .o_id_pc4(id_pc4_b), .o_fault(fault_b), .o_fault_pc(fault_pc_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".pc"}, pc, 32'h0);
    check({tag, ".valid"}, {31'h0, id_valid}, 32'h0);
    check({tag, ".inst"}, id_inst, 32'h13);
    check({tag, ".id_pc"}, id_pc, 32'h0);
    check({tag, ".pc4"}, id_pc4, 32'h4);
    check({tag, ".fault"}, {31'h0, fault}, 32'h0);
    check({tag, ".fault_pc"}, fault_pc, 32'h0);
  endtask

  task automatic check_id(input string tag, input logic [31:0] p);
    check({tag, ".valid"}, {31'h0, id_valid}, 32'h1);
    check({tag, ".id_pc"}, id_pc, p);
    check({tag, ".inst"}, id_inst, 32'h1000 + (p >> 2));
    check({tag, ".pc4"}, id_pc4, p + 32'h4);
  endtask

  initial begin
    rst = 1'b1; rst_b = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; ready = 1'b1;
    step();
    check_reset("reset");
    rst = 1'b0;
    step(); check_id("run0", 32'h0); check("run0.o_pc", pc, 32'h4);
    step(); check_id("run1", 32'h4); check("run1.o_pc", pc, 32'h8);
    step(); check_id("run2", 32'h8); check("run2.o_pc", pc, 32'hc);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check_id("stall", 32'h8); check("stall.o_pc", pc, 32'hc);
    end
    ready = 1'b1;
    step(); check_id("resume", 32'hc); check("resume.o_pc", pc, 32'h10);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    check("redir.valid", {31'h0, id_valid}, 32'h0);
    check("redir.inst", id_inst, 32'h13);
    check("redir.o_pc", pc, 32'h40);
    redirect = 1'b0;
    step(); check_id("redir_tgt", 32'h40); check("redir_tgt.o_pc", pc, 32'h44);
    ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
    step();
    check("redir_stall.valid", {31'h0, id_valid}, 32'h0);
    check("redir_stall.o_pc", pc, 32'h80);
    redirect = 1'b0;
    step(); check_id("redir_stall_tgt", 32'h80); check("redir_stall_tgt.o_pc", pc, 32'h84);
    step(); check_id("redir_stall_hold", 32'h80); check("redir_stall_hold.o_pc", pc, 32'h84);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h42;
    step();
    check("misal.fault", {31'h0, fault}, 32'h1);
    check("misal.fault_pc", fault_pc, 32'h42);
    check("misal.valid", {31'h0, id_valid}, 32'h0);
    check("misal.o_pc", pc, 32'h84);
    redirect = 1'b0;
    step();
    check("halt.fault", {31'h0, fault}, 32'h1);
    check("halt.valid", {31'h0, id_valid}, 32'h0);
    check("halt.o_pc", pc, 32'h84);
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    check("unhalt.fault", {31'h0, fault}, 32'h0);
    check("unhalt.o_pc", pc, 32'h10);
    check("unhalt.valid", {31'h0, id_valid}, 32'h0);
    redirect = 1'b0;
    step(); check_id("unhalt_tgt", 32'h10);
    ready = 1'b0;
    step(); check_id("pre_rst_stall", 32'h10);
    rst = 1'b1;
    step(); check_reset("rst_stall");
    rst = 1'b0; ready = 1'b1;
    step(); check_id("rst_stall_restart", 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    check("oor.fault", {31'h0, fault}, 32'h1);
    check("oor.fault_pc", fault_pc, 32'h100);
    rst = 1'b1; redirect_pc = 32'h20;
    step(); check_reset("rst_halt");
    rst = 1'b0; redirect = 1'b0;
    step(); check_id("rst_halt_restart", 32'h0);
    step();
    rst_b = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("runoff.valid", {31'h0, id_valid_b}, 32'h1);
      check("runoff.id_pc", id_pc_b, 32'(k * 4));
      check("runoff.inst", id_inst_b, 32'h1000 + 32'(k));
      check("runoff.fault", {31'h0, fault_b}, 32'h0);
    end
    check("runoff.o_pc", pc_b, 32'h10);
    step();
    check("runoff_end.fault", {31'h0, fault_b}, 32'h1);
    check("runoff_end.fault_pc", fault_pc_b, 32'h10);
    check("runoff_end.valid", {31'h0, id_valid_b}, 32'h0);
    check("runoff_end.o_pc", pc_b, 32'h10);
    step();
    check("runoff_hold.fault", {31'h0, fault_b}, 32'h1);
    check("runoff_hold.valid", {31'h0, id_valid_b}, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage sitting directly upstream of the instruction memory: it owns the program counter, drives the memory's PC input, captures the returned word into an IF/ID pipeline register and hands it to decode over a valid/ready handshake. It applies branch/jump redirects from execute and halts with a fault on misaligned or out-of-range fetch addresses.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `IMEM_SIZE`, default 256: instruction memory size in bytes. A fetch at PC ≥ IMEM_SIZE − 3 is out of range.
- `i_clk` input 1: the single clock. All state updates on its rising edge.
- `i_rst` input 1: reset, synchronous and active-high.
- `o_pc` output 32: current fetch PC, driven to the instruction memory.
- `i_inst` input 32: instruction word returned combinationally for `o_pc`.
- `i_redirect` input 1: taken branch/jump from execute, valid this cycle.
- `i_redirect_pc` input 32: redirect target.
- `o_id_valid` output 1: IF/ID register holds an instruction.
- `i_id_ready` input 1: decode accepts the IF/ID contents this cycle.
- `o_id_inst` output 32: registered instruction.
- `o_id_pc` output 32: PC of `o_id_inst`.
- `o_id_pc4` output 32: `o_id_pc` + 4, for link registers.
- `o_fault` output 1: fetch halted on a bad address.
- `o_fault_pc` output 32: offending address. It is valid while `o_fault` is high.

## Operation
- The state machine has two states, RUN and HALT. Reset enters RUN.
- Define `adv = !o_id_valid || i_id_ready`. This means the IF/ID slot is free or is being drained.
- **Bad address:** `bad(a) = (a[1:0] != 0) || (a > IMEM_SIZE − 4)`. The comparison is unsigned 32-bit.
- Priority each cycle is i_rst > i_redirect > normal fetch.
- **Redirect** (any state):
  - IF/ID is flushed: `o_id_valid` <= 0. An entry being handshaken the same cycle counts as consumed by decode.
  - If `bad(i_redirect_pc)`: go to HALT, `o_fault_pc` <= target, and the PC is unchanged.
  - Otherwise: PC <= target and go to RUN. This also exits HALT.
- **RUN, no redirect, `adv`:**
  - If `bad(o_pc)`: go to HALT, `o_fault_pc` <= `o_pc`, `o_id_valid` <= 0.
  - Otherwise: capture `o_id_inst` <= `i_inst`, `o_id_pc` <= `o_pc`, `o_id_pc4` <= `o_pc` + 4, and set `o_id_valid` <= 1. Then PC <= PC + 4, wrapping modulo 2^32.
- **RUN, no redirect, !adv (stall):** the PC and all IF/ID fields hold.
- **HALT:**
  - No fetch. The PC holds.
  - `o_id_valid` stays 0 once any pending entry drains. An entry present on HALT entry is cleared, because HALT is entered only via the two paths above, both of which clear valid.
  - `o_fault` = (state == HALT).
- An empty IF/ID register shows `o_id_inst` = 32'h0000_0013 (NOP).

## Timing
- **Reset values:**
  - `o_pc` = RESET_PC
  - `o_id_valid` = 0
  - `o_id_inst` = 32'h0000_0013
  - `o_id_pc` = 0
  - `o_id_pc4` = 4
  - `o_fault` = 0
  - `o_fault_pc` = 0
- Reset asserted mid-operation overrides any redirect or handshake in the same cycle.
- Fetch-to-decode latency is 1 cycle. The word for PC p appears on `o_id_*` the cycle after `o_pc` = p with `adv`.
- Throughput is 1 instruction per cycle while `i_id_ready` = 1.
- Redirect penalty: the target word is in IF/ID 2 cycles after `i_redirect` is sampled (cycle 0: PC loads; cycle 1: captured). No wrong-path instruction is presented after the redirect edge.
- `o_id_*` are registered. `o_pc` comes straight from the PC register. `o_fault` is registered.

## Structure
- Shared package `lake_pkg`:
  - `NOP_INST` = 32'h0000_0013
  - `fetch_state_t` = {RUN, HALT}
  - `INST_W` = 32
- Natural sub-module: `if_id_reg`. It holds valid, inst, pc and pc4, and has load/flush/hold controls. `fetch_stage` keeps the PC and the FSM.

## Test plan
- **Reset then free-run** (RESET_PC = 0, i_id_ready = 1, memory word k = 0x1000+k): `o_id_pc` = 0, 4, 8 with `o_id_inst` = 0x1000, 0x1001, 0x1002 on consecutive cycles. `o_id_pc4` = `o_id_pc` + 4.
- **Stall:** drop `i_id_ready` for 3 cycles while `o_id_pc` = 8. `o_pc` stays 12 and `o_id_pc` stays 8. Resume gives 12 next.
- **Redirect:** redirect to 0x40 while `o_id_valid` = 1. Next cycle `o_id_valid` = 0 and `o_pc` = 0x40. The cycle after, `o_id_pc` = 0x40. Also apply redirect + stall together: the redirect still flushes and loads.
- **Misaligned redirect** to 0x42: `o_fault` = 1, `o_fault_pc` = 0x42, `o_id_valid` stays 0. A later redirect to 0x10 clears the fault and fetches 0x10.
- **Run-off** with IMEM_SIZE = 16, sequential from 0: the instructions at 0, 4, 8, 12 are delivered. At PC 16, `o_fault` = 1 and `o_fault_pc` = 16.
- **Reset during HALT and during a stall:** all outputs return to their reset values on the next edge, and fetch restarts at RESET_PC.
